dpbr_8_32: RTL and testbench



---
 rtl/dpbr_8_32.sv | 45 ++++
 tb/tb_dpbr_8_32.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/dpbr_8_32.sv
// 4 KiB dual-port RAM: 32-bit read/write word port A, 8-bit write-only byte port B, one clock.
// Read latency 1 cycle, read-first; no backpressure, both ports accept a write every cycle.
module dpbr_8_32 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wea,
  input  logic [9:0]  addra,
  input  logic [31:0] dina,
  output logic [31:0] douta,
  input  logic        web,
  input  logic [11:0] addrb,
  input  logic [7:0]  dinb
);

  logic [31:0] r_mem [1024];
  logic [31:0] r_douta;
  logic [9:0]  w_b_word;
  logic [4:0]  w_b_lsb;

  assign w_b_word = addrb[11:2];
  assign w_b_lsb  = {addrb[1:0], 3'b000};

  // Port B's byte update is scheduled after port A's word write, so it owns its lane on a collision.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (wea) begin
        r_mem[addra] <= dina;
      end
      if (web) begin
        r_mem[w_b_word][w_b_lsb +: 8] <= dinb;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_douta <= 32'h0000_0000;
    end else begin
      r_douta <= r_mem[addra];
    end
  end

  assign douta = r_douta;

endmodule

// File: tb/tb_dpbr_8_32.sv
// Directed plus randomized bench for dpbr_8_32 against a byte-array reference model.
module tb_dpbr_8_32;

  logic        clk;
  logic        reset_n;
  logic        wea;
  logic [9:0]  addra;
  logic [31:0] dina;
  logic [31:0] douta;
  logic        web;
  logic [11:0] addrb;
  logic [7:0]  dinb;

  int unsigned n_vec;
  int unsigned n_bad;
  logic [7:0]  m_bytes [4096];

  dpbr_8_32 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .wea     (wea),
    .addra   (addra),
    .dina    (dina),
    .douta   (douta),
    .web     (web),
    .addrb   (addrb),
    .dinb    (dinb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] m_word(input int w);
    return {m_bytes[4*w+3], m_bytes[4*w+2], m_bytes[4*w+1], m_bytes[4*w]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, advance the model across the edge, then compare douta just after it.
  task automatic step(input logic a_we, input logic [9:0] a_ad, input logic [31:0] a_d,
                      input logic b_we, input logic [11:0] b_ad, input logic [7:0] b_d);
    logic [31:0] exp;
    @(negedge clk);
    wea = a_we; addra = a_ad; dina = a_d;
    web = b_we; addrb = b_ad; dinb = b_d;
    @(posedge clk);
    if (!reset_n) begin
      exp = 32'h0;
    end else begin
      exp = m_word(int'(a_ad));
      if (a_we) begin
        for (int k = 0; k < 4; k++) m_bytes[4*int'(a_ad)+k] = a_d[8*k +: 8];
      end
      if (b_we) m_bytes[int'(b_ad)] = b_d;
    end
    #1;
    chk("douta", douta, exp);
    @(negedge clk);
    wea = 1'b0; web = 1'b0;
  endtask

  task automatic rd(input logic [9:0] a);
    step(1'b0, a, 32'h0, 1'b0, 12'h0, 8'h0);
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    for (int i = 0; i < 4096; i++) m_bytes[i] = 8'h00;
    reset_n = 1'b0;
    wea = 1'b0; addra = '0; dina = '0;
    web = 1'b0; addrb = '0; dinb = '0;
    #12;
    chk("reset_douta", douta, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Establish known contents so the model's zeros are real.
    for (int w = 0; w < 1024; w++) step(1'b1, 10'(w), 32'h0, 1'b0, 12'h0, 8'h0);

    // Byte packing.
    step(1'b0, 10'h0, 32'h0, 1'b1, 12'h000, 8'h11);
    step(1'b0, 10'h0, 32'h0, 1'b1, 12'h001, 8'h22);
    step(1'b0, 10'h0, 32'h0, 1'b1, 12'h002, 8'h33);
    step(1'b0, 10'h0, 32'h0, 1'b1, 12'h003, 8'h44);
    rd(10'h000);
    chk("pack", douta, 32'h4433_2211);

    // Half select and top boundary.
    step(1'b0, 10'h0, 32'h0, 1'b1, 12'h800, 8'hAB);
    step(1'b0, 10'h0, 32'h0, 1'b1, 12'hFFF, 8'hCD);
    rd(10'h200);
    chk("half", douta, 32'h0000_00AB);
    rd(10'h3FF);
    chk("top", douta, 32'hCD00_0000);

    // Read-first against a same-edge port B write.
    step(1'b1, 10'd5, 32'h0102_0304, 1'b0, 12'h0, 8'h0);
    step(1'b0, 10'd5, 32'h0, 1'b1, 12'h014, 8'hFF);
    chk("read_first", douta, 32'h0102_0304);
    rd(10'd5);
    chk("after_write", douta, 32'h0102_03FF);

    // Same-word collision: port B owns its lane.
    step(1'b1, 10'd7, 32'hAAAA_AAAA, 1'b1, 12'h01E, 8'h55);
    rd(10'd7);
    chk("collision", douta, 32'hAA55_AAAA);

    // Asynchronous reset mid-operation.
    rd(10'h000);
    chk("pre_reset", douta, 32'h4433_2211);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset", douta, 32'h0);
    step(1'b1, 10'h000, 32'hDEAD_BEEF, 1'b1, 12'h001, 8'h99);
    chk("held_in_reset", douta, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    rd(10'h000);
    chk("kept_contents", douta, 32'h4433_2211);

    // Streaming bytes one per cycle.
    for (int i = 0; i < 64; i++) step(1'b0, 10'h0, 32'h0, 1'b1, 12'(4 + i), 8'(i));
    for (int w = 1; w <= 16; w++) begin
      rd(10'(w));
      chk("stream", douta, {8'(4*w-1), 8'(4*w-2), 8'(4*w-3), 8'(4*w-4)});
    end

    // Random traffic, biased toward a small window so collisions and read-after-write occur.
    for (int i = 0; i < 3000; i++) begin
      logic        a_we, b_we;
      logic [9:0]  a_ad;
      logic [11:0] b_ad;
      a_we = 1'($urandom_range(0, 1));
      b_we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) begin
        a_ad = 10'($urandom_range(0, 15));
        b_ad = 12'($urandom_range(0, 63));
      end else begin
        a_ad = 10'($urandom);
        b_ad = 12'($urandom);
      end
      step(a_we, a_ad, $urandom, b_we, b_ad, 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
